video_in_wb_writer: RTL and testbench

Downstream stage of the video-input pixel FIFO. It waits until the FIFO reports that a full packet is buffered, then drains exactly NB_PACK 32-bit words into the frame buffer in system memory. Each packet is written as one Wishbone classic incrementing-burst master cycle, with write addresses generated sequentially across the frame. It also signals frame completion to the rest of the video-in path.

---
 rtl/video_in_pkg.sv | 24 ++
 rtl/wb_addr_gen.sv | 77 +++++++
 rtl/video_in_wb_writer.sv | 173 +++++++++++++++++
 tb/tb_video_in_wb_writer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_in_pkg.sv
// Shared video-in definitions: writer FSM states, default sizing and Wishbone CTI codes.
package video_in_pkg;

    localparam int DATA_SIZE_DEF   = 32;
    localparam int NB_PACK_DEF     = 16;
    localparam int FRAME_WORDS_DEF = 76800;

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_END  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_REQ    = 3'd2,
        ST_POP    = 3'd3,
        ST_SETTLE = 3'd4,
        ST_END    = 3'd5
    } wr_state_t;

    function automatic logic [2:0] burst_cti(input logic last_word);
        return last_word ? CTI_END : CTI_INCR;
    endfunction

endpackage

// File: rtl/wb_addr_gen.sv
// Frame word index, frame-end detection, frame buffer selection and byte address.
// DOUBLE_BUFFER_EN: alternate between frame_base0 and frame_base1 on each completed frame.
module wb_addr_gen #(
    parameter int ADDR_W      = 32,
    parameter int FRAME_WORDS = 76800
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              inc,
    input  logic              restart,
    input  logic              frame_ack,
    input  logic [ADDR_W-1:0] frame_base0,
    input  logic [ADDR_W-1:0] frame_base1,
    output logic [ADDR_W-1:0] addr,
    output logic              frame_end,
    output logic              buf_sel
);
    localparam int IDX_W = $clog2(FRAME_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

    logic [IDX_W-1:0]  word_idx_r;
    logic              frame_end_r;
    logic [ADDR_W-1:0] base_s;

    // Word index wraps on the last word of the frame; the flag remembers that until END
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            word_idx_r  <= {IDX_W{1'b0}};
            frame_end_r <= 1'b0;
        end else if (restart) begin
            word_idx_r  <= {IDX_W{1'b0}};
            frame_end_r <= 1'b0;
        end else if (inc) begin
            if (word_idx_r == LAST_IDX) begin
                word_idx_r  <= {IDX_W{1'b0}};
                frame_end_r <= 1'b1;
            end else begin
                word_idx_r  <= word_idx_r + IDX_W'(1);
                frame_end_r <= frame_end_r;
            end
        end else if (frame_ack) begin
            word_idx_r  <= word_idx_r;
            frame_end_r <= 1'b0;
        end else begin
            word_idx_r  <= word_idx_r;
            frame_end_r <= frame_end_r;
        end
    end

`ifdef DOUBLE_BUFFER_EN
    logic buf_sel_r;

    // Toggle the target buffer when END retires a completed frame
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            buf_sel_r <= 1'b0;
        end else if (frame_ack && frame_end_r) begin
            buf_sel_r <= ~buf_sel_r;
        end else begin
            buf_sel_r <= buf_sel_r;
        end
    end

    assign base_s  = buf_sel_r ? frame_base1 : frame_base0;
    assign buf_sel = buf_sel_r;
`else
    logic unused_base1_s;

    assign unused_base1_s = ^frame_base1;
    assign base_s         = frame_base0;
    assign buf_sel        = 1'b0;
`endif

    assign addr      = base_s + ADDR_W'({word_idx_r, 2'b00});
    assign frame_end = frame_end_r;

endmodule

// File: rtl/video_in_wb_writer.sv
// Drains NB_PACK-word packets from the video-in FIFO into the frame buffer as Wishbone bursts.
// DOUBLE_BUFFER_EN: frames alternate between frame_base0 and frame_base1.
module video_in_wb_writer
    import video_in_pkg::*;
#(
    parameter int DATA_SIZE   = DATA_SIZE_DEF,
    parameter int ADDR_W      = 32,
    parameter int NB_PACK     = NB_PACK_DEF,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic [DATA_SIZE-1:0] fifo_data,
    input  logic                 fifo_pack_available,
    output logic                 fifo_r_ack,
    input  logic                 frame_start,
    input  logic [ADDR_W-1:0]    frame_base0,
    input  logic [ADDR_W-1:0]    frame_base1,
    output logic                 frame_done,
    output logic                 buf_sel,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [ADDR_W-1:0]    wb_adr_o,
    output logic [DATA_SIZE-1:0] wb_dat_o,
    output logic [3:0]           wb_sel_o,
    output logic [2:0]           wb_cti_o,
    output logic [1:0]           wb_bte_o,
    input  logic                 wb_ack_i
);
    localparam int BC_W = $clog2(NB_PACK + 1);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(NB_PACK);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(NB_PACK - 1);

    wr_state_t             state_r, state_s;
    logic                  settle_r, armed_r, pending_r;
    logic [BC_W-1:0]       burst_cnt_r;
    logic                  restart_s, inc_s, frame_ack_s, frame_end_s;
    logic [ADDR_W-1:0]     addr_s;
    logic                  cyc_r, stb_r, we_r, r_ack_r, frame_done_r;
    logic [ADDR_W-1:0]     adr_r;
    logic [DATA_SIZE-1:0]  dat_r;
    logic [2:0]            cti_r;

    // A pending restart, or one arriving in END, wins over clearing armed at frame end
    assign restart_s   = ((state_r == ST_IDLE) && frame_start) ||
                         ((state_r == ST_END) && (pending_r || frame_start));
    assign inc_s       = (state_r == ST_POP);
    assign frame_ack_s = (state_r == ST_END);

    wb_addr_gen #(
        .ADDR_W      (ADDR_W),
        .FRAME_WORDS (FRAME_WORDS)
    ) u_addr_gen (
        .clk         (clk),
        .nRST        (nRST),
        .inc         (inc_s),
        .restart     (restart_s),
        .frame_ack   (frame_ack_s),
        .frame_base0 (frame_base0),
        .frame_base1 (frame_base1),
        .addr        (addr_s),
        .frame_end   (frame_end_s),
        .buf_sel     (buf_sel)
    );

    // State register
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (armed_r && fifo_pack_available) state_s = ST_LOAD;
                else                                state_s = ST_IDLE;
            end
            ST_LOAD: state_s = ST_REQ;
            ST_REQ: begin
                if (wb_ack_i) state_s = ST_POP;
                else          state_s = ST_REQ;
            end
            ST_POP: state_s = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_r) begin
                    if (burst_cnt_r < BC_FULL) state_s = ST_LOAD;
                    else                       state_s = ST_END;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_END:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Settle timer, burst word count and frame arming
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            settle_r    <= 1'b0;
            burst_cnt_r <= {BC_W{1'b0}};
            armed_r     <= 1'b0;
            pending_r   <= 1'b0;
        end else begin
            settle_r <= (state_r == ST_SETTLE) ? ~settle_r : 1'b0;
            case (state_r)
                ST_POP:  burst_cnt_r <= burst_cnt_r + BC_W'(1);
                ST_END:  burst_cnt_r <= {BC_W{1'b0}};
                default: burst_cnt_r <= burst_cnt_r;
            endcase
            if (state_r == ST_END) begin
                pending_r <= 1'b0;
                if (pending_r || frame_start) armed_r <= 1'b1;
                else if (frame_end_s)         armed_r <= 1'b0;
                else                          armed_r <= armed_r;
            end else if (frame_start) begin
                if (state_r == ST_IDLE) armed_r   <= 1'b1;
                else                    pending_r <= 1'b1;
            end else begin
                armed_r   <= armed_r;
                pending_r <= pending_r;
            end
        end
    end

    // Registered bus outputs; strobes follow the state being entered
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cyc_r        <= 1'b0;
            stb_r        <= 1'b0;
            we_r         <= 1'b0;
            r_ack_r      <= 1'b0;
            frame_done_r <= 1'b0;
            adr_r        <= {ADDR_W{1'b0}};
            dat_r        <= {DATA_SIZE{1'b0}};
            cti_r        <= 3'b000;
        end else begin
            cyc_r        <= (state_s == ST_LOAD) || (state_s == ST_REQ) ||
                            (state_s == ST_POP)  || (state_s == ST_SETTLE);
            stb_r        <= (state_s == ST_REQ);
            we_r         <= (state_s == ST_REQ);
            r_ack_r      <= (state_s == ST_POP);
            frame_done_r <= (state_s == ST_END) && frame_end_s;
            if (state_r == ST_LOAD) begin
                dat_r <= fifo_data;
                adr_r <= addr_s;
                cti_r <= burst_cti(burst_cnt_r == BC_LAST);
            end else begin
                dat_r <= dat_r;
                adr_r <= adr_r;
                cti_r <= cti_r;
            end
        end
    end

    assign wb_cyc_o   = cyc_r;
    assign wb_stb_o   = stb_r;
    assign wb_we_o    = we_r;
    assign wb_adr_o   = adr_r;
    assign wb_dat_o   = dat_r;
    assign wb_cti_o   = cti_r;
    assign wb_sel_o   = 4'hF;
    assign wb_bte_o   = 2'b00;
    assign fifo_r_ack = r_ack_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_video_in_wb_writer.sv
// Directed bench for video_in_wb_writer: FIFO model, Wishbone slave with optional wait states.
module tb_video_in_wb_writer;
    localparam int NB = 16;
    localparam int FW = 32;
    localparam logic [31:0] BASE0 = 32'h1000_0000;
    localparam logic [31:0] BASE1 = 32'h2000_0400;

    logic        clk = 1'b0;
    logic        nRST, fifo_pack_available, fifo_r_ack, frame_start, frame_done, buf_sel;
    logic [31:0] fifo_data, wb_adr_o, wb_dat_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;

    int checks, errors;
    int rd_ptr, wait_left, burst_word, exp_idx, wr_cnt, fd_cnt, cyc_cnt;
    logic [31:0] pipe_q, exp_base, hold_adr, hold_dat;
    bit stb_prev, ack_prev, inject_wait;

    video_in_wb_writer #(.NB_PACK(NB), .FRAME_WORDS(FW)) dut (
        .clk(clk), .nRST(nRST), .fifo_data(fifo_data),
        .fifo_pack_available(fifo_pack_available), .fifo_r_ack(fifo_r_ack),
        .frame_start(frame_start), .frame_base0(BASE0), .frame_base1(BASE1),
        .frame_done(frame_done), .buf_sel(buf_sel),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int k);
        return 32'hC0DE_0000 + 32'(k);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // FIFO with delayed read data plus a Wishbone slave that checks every accepted write
    task automatic bus_model();
        logic [2:0] exp_cti;
        forever begin
            @(negedge clk);
            if (wb_cyc_o) cyc_cnt++;
            if (frame_done) begin
                fd_cnt++;
                check_eq("done_cyc_low", wb_cyc_o, 32'd0);
            end
            if (fifo_r_ack) rd_ptr++;
            fifo_data = pipe_q;
            pipe_q    = pat(rd_ptr);
            if (!nRST) begin
                wb_ack_i = 1'b0; ack_prev = 1'b0; stb_prev = 1'b0;
                burst_word = 0; wait_left = 0;
            end else begin
                check_eq("r_ack", fifo_r_ack, ack_prev);
                if (wb_cyc_o && wb_stb_o) begin
                    if (!stb_prev) begin
                        wait_left = (inject_wait && burst_word == 5) ? 3 : 0;
                        hold_adr  = wb_adr_o;
                        hold_dat  = wb_dat_o;
                    end else begin
                        check_eq("wait_adr", wb_adr_o, hold_adr);
                        check_eq("wait_dat", wb_dat_o, hold_dat);
                    end
                    if (wait_left > 0) begin
                        wait_left--;
                        wb_ack_i = 1'b0;
                    end else begin
                        wb_ack_i = 1'b1;
                        wr_cnt++;
                        exp_cti = (burst_word == NB - 1) ? 3'b111 : 3'b010;
                        check_eq("adr", wb_adr_o, exp_base + 32'(exp_idx * 4));
                        check_eq("dat", wb_dat_o, pat(rd_ptr));
                        check_eq("cti", wb_cti_o, exp_cti);
                        check_eq("we", wb_we_o, 32'd1);
                        exp_idx++;
                        burst_word = (burst_word == NB - 1) ? 0 : burst_word + 1;
                    end
                end else begin
                    wb_ack_i = 1'b0;
                end
                ack_prev = wb_ack_i;
                stb_prev = wb_stb_o;
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_cyc(input logic level, input string tag);
        int  n = 0;
        bit  ok = 1'b0;
        while (!ok && n < 300) begin
            @(negedge clk); #1;
            if (wb_cyc_o == level) ok = 1'b1;
            n++;
        end
        check_eq({tag, "_wait"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_word(input int w, input string tag);
        int n = 0;
        bit ok = 1'b0;
        while (!ok && n < 300) begin
            @(negedge clk); #1;
            if (wb_cyc_o && burst_word == w) ok = 1'b1;
            n++;
        end
        check_eq({tag, "_word"}, 32'(ok), 32'd1);
    endtask

    task automatic run_burst(input string tag, input int exp_cycles);
        int c0 = cyc_cnt;
        int w0 = wr_cnt;
        wait_cyc(1'b1, tag);
        wait_cyc(1'b0, tag);
        check_eq({tag, "_cycles"}, 32'(cyc_cnt - c0), 32'(exp_cycles));
        check_eq({tag, "_writes"}, 32'(wr_cnt - w0), 32'(NB));
    endtask

    initial begin
        int c0, w0;
        bit ok;
        logic exp_sel1;
        logic [31:0] base_f2;
`ifdef DOUBLE_BUFFER_EN
        exp_sel1 = 1'b1; base_f2 = BASE1;
`else
        exp_sel1 = 1'b0; base_f2 = BASE0;
`endif
        checks = 0; errors = 0;
        nRST = 1'b0; frame_start = 1'b0; fifo_pack_available = 1'b0;
        fifo_data = 32'd0; wb_ack_i = 1'b0;
        rd_ptr = 0; pipe_q = pat(0); wait_left = 0; burst_word = 0;
        exp_idx = 0; exp_base = BASE0; wr_cnt = 0; fd_cnt = 0; cyc_cnt = 0;
        stb_prev = 1'b0; ack_prev = 1'b0; inject_wait = 1'b0;
        hold_adr = 32'd0; hold_dat = 32'd0;
        fork
            bus_model();
        join_none

        repeat (3) @(posedge clk); #1;
        check_eq("rst_cyc", wb_cyc_o, 32'd0);
        check_eq("rst_stb", wb_stb_o, 32'd0);
        check_eq("rst_we", wb_we_o, 32'd0);
        check_eq("rst_rack", fifo_r_ack, 32'd0);
        check_eq("rst_done", frame_done, 32'd0);
        check_eq("rst_bufsel", buf_sel, 32'd0);
        check_eq("rst_adr", wb_adr_o, 32'd0);
        check_eq("rst_dat", wb_dat_o, 32'd0);
        check_eq("rst_cti", wb_cti_o, 32'd0);
        check_eq("rst_sel", wb_sel_o, 32'hF);
        check_eq("rst_bte", wb_bte_o, 32'd0);
        @(negedge clk);
        nRST = 1'b1;

        // packets available but no frame armed
        fifo_pack_available = 1'b1;
        repeat (20) @(posedge clk); #1;
        check_eq("unarmed_writes", 32'(wr_cnt), 32'd0);

        // frame 1: wait states on word 5 of the first burst
        inject_wait = 1'b1;
        pulse_start();
        run_burst("f1_b0", 5 * NB + 3);
        inject_wait = 1'b0;
        run_burst("f1_b1", 5 * NB);
        check_eq("f1_done", 32'(fd_cnt), 32'd1);
        check_eq("f1_rack_total", 32'(rd_ptr), 32'(2 * NB));
        w0 = wr_cnt;
        repeat (30) @(posedge clk); #1;
        check_eq("f1_disarmed", 32'(wr_cnt), 32'(w0));
        check_eq("f1_bufsel", buf_sel, 32'(exp_sel1));

        // frame 2
        exp_idx = 0; exp_base = base_f2;
        pulse_start();
        run_burst("f2_b0", 5 * NB);
        run_burst("f2_b1", 5 * NB);
        check_eq("f2_done", 32'(fd_cnt), 32'd2);
        repeat (3) @(posedge clk); #1;
        check_eq("f2_bufsel", buf_sel, 32'd0);

        // frame_start at word 7 is deferred to the end of the burst
        exp_idx = 0; exp_base = BASE0;
        pulse_start();
        c0 = cyc_cnt;
        wait_cyc(1'b1, "mid");
        wait_word(7, "mid");
        pulse_start();
        wait_cyc(1'b0, "mid");
        check_eq("mid_cycles", 32'(cyc_cnt - c0), 32'(5 * NB));
        check_eq("mid_idx", 32'(exp_idx), 32'(NB));
        exp_idx = 0;

        // pack_available drops at word 4; burst still completes
        c0 = cyc_cnt; w0 = wr_cnt;
        wait_cyc(1'b1, "drop");
        wait_word(4, "drop");
        fifo_pack_available = 1'b0;
        wait_cyc(1'b0, "drop");
        check_eq("drop_cycles", 32'(cyc_cnt - c0), 32'(5 * NB));
        check_eq("drop_writes", 32'(wr_cnt - w0), 32'(NB));
        check_eq("drop_no_done", 32'(fd_cnt), 32'd2);
        w0 = wr_cnt;
        repeat (30) @(posedge clk); #1;
        check_eq("drop_idle", 32'(wr_cnt), 32'(w0));

        // reset during REQ abandons the cycle and disarms
        fifo_pack_available = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(posedge clk); #1;
            if (wb_stb_o) ok = 1'b1;
        end
        check_eq("rst_req_seen", 32'(ok), 32'd1);
        nRST = 1'b0;
        #1;
        check_eq("arst_cyc", wb_cyc_o, 32'd0);
        check_eq("arst_stb", wb_stb_o, 32'd0);
        check_eq("arst_rack", fifo_r_ack, 32'd0);
        repeat (3) @(negedge clk);
        nRST = 1'b1;
        w0 = wr_cnt;
        repeat (40) @(posedge clk); #1;
        check_eq("arst_no_write", 32'(wr_cnt), 32'(w0));
        check_eq("arst_cyc_idle", wb_cyc_o, 32'd0);
        check_eq("arst_bufsel", buf_sel, 32'd0);
        exp_idx = 0; exp_base = BASE0;
        pulse_start();
        run_burst("post_rst", 5 * NB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
